// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite responder memory.
package axi_lite_pkg;

    // Width of the AXI-Lite data link the merge helper is sized for.
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    // Replace only the bytes whose strobe bit is set; other bytes keep the old word.
    function automatic logic [AXI_DATA_W-1:0] strb_merge(
        input logic [AXI_DATA_W-1:0] old_word,
        input logic [AXI_DATA_W-1:0] new_word,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < AXI_STRB_W; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_resp_mem.sv
// AXI4-Lite slave backed by a small flop-based register file.
// AW and W are held in independent one-deep buffers and committed together;
// reads run through a small FSM that inserts a fixed number of wait cycles.
module axi_lite_resp_mem
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = AXI_DATA_W,
    parameter int                    DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    RD_LATENCY = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORD_W     = ADDR_WIDTH - BYTE_SHIFT;
    localparam int CNT_W      = 4;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    resp_e                 bresp_q, bresp_d;

    rd_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    resp_e                 rresp_q, rresp_d;

    // Decode uses one extra bit so an address below BASE_ADDR shows up as a borrow.
    logic [ADDR_WIDTH:0]   aw_off, ar_off;
    logic                  aw_in_range, ar_in_range;
    logic [IDX_W-1:0]      aw_idx, ar_idx;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic                  unused_bits;

    assign aw_off      = {1'b0, aw_addr_q} - {1'b0, BASE_ADDR};
    assign ar_off      = {1'b0, ar_addr_q} - {1'b0, BASE_ADDR};
    assign aw_in_range = !aw_off[ADDR_WIDTH] && (aw_off[ADDR_WIDTH-1:BYTE_SHIFT] < WORD_W'(DEPTH));
    assign ar_in_range = !ar_off[ADDR_WIDTH] && (ar_off[ADDR_WIDTH-1:BYTE_SHIFT] < WORD_W'(DEPTH));
    assign aw_idx      = aw_off[BYTE_SHIFT +: IDX_W];
    assign ar_idx      = ar_off[BYTE_SHIFT +: IDX_W];
    assign unused_bits = ^{awprot, arprot, aw_off[BYTE_SHIFT-1:0], ar_off[BYTE_SHIFT-1:0]};

    assign aw_hs  = awvalid && awready_q;
    assign w_hs   = wvalid && wready_q;
    assign ar_hs  = arvalid && arready_q;
    assign commit = aw_full_q && w_full_q && !bvalid_q;

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    // Write path: capture AW/W independently, commit once both are held and B is free.
    always_comb begin
        mem_d     = mem_q;
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_in_range ? OKAY : DECERR;
            if (aw_in_range) begin
                mem_d[aw_idx] = strb_merge(mem_q[aw_idx], w_data_q, w_strb_q);
            end
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
    end

    // Read FSM: accept AR, count down the latency, then present R until accepted.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ar_addr_d = ar_addr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ar_addr_d = araddr;
                    cnt_d     = CNT_W'(RD_LATENCY);
                    state_d   = R_WAIT;
                end
            end
            R_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d  = ar_in_range ? mem_q[ar_idx] : '0;
                    rresp_d  = ar_in_range ? OKAY : DECERR;
                    rvalid_d = 1'b1;
                    state_d  = R_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
        arready_d = (state_d == R_IDLE);
    end

    // State registers; reset clears memory and drops any pending transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            state_q   <= R_IDLE;
            cnt_q     <= '0;
            ar_addr_q <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            mem_q     <= mem_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ar_addr_q <= ar_addr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_resp_mem.sv
// Scoreboard bench for axi_lite_resp_mem: tasks issue traffic and push expected
// responses; a negedge monitor pops and compares whenever B or R completes.
module tb_axi_lite_resp_mem;

    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int          RD_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int          checks = 0;
    int          errors = 0;
    int          b_seen = 0;
    int          r_seen = 0;
    bit          rand_ready = 0;

    logic [1:0]  exp_b[$];
    logic [1:0]  exp_rresp[$];
    logic [31:0] exp_rdata[$];
    logic [31:0] model_mem[DEPTH];

    axi_lite_resp_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit model_in_range(input logic [31:0] addr);
        return (addr >= BASE) && (((addr - BASE) >> 2) < DEPTH);
    endfunction

    // Monitor: compare completed responses and require held responses to stay put.
    logic        b_hold = 0, r_hold = 0;
    logic [1:0]  b_hold_resp, r_hold_resp;
    logic [31:0] r_hold_data;
    always @(negedge clk) begin
        if (rst) begin
            b_hold = 0;
            r_hold = 0;
        end else begin
            if (b_hold) begin
                checkOutput("bvalid_stable", bvalid, 1);
                checkOutput("bresp_stable", bresp, b_hold_resp);
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) checkOutput("b_unexpected", 1, 0);
                else checkOutput("bresp", bresp, exp_b.pop_front());
                b_seen++;
                b_hold = 0;
            end else begin
                b_hold = bvalid;
                b_hold_resp = bresp;
            end
            if (r_hold) begin
                checkOutput("rvalid_stable", rvalid, 1);
                checkOutput("rdata_stable", rdata, r_hold_data);
                checkOutput("rresp_stable", rresp, r_hold_resp);
            end
            if (rvalid && rready) begin
                if (exp_rdata.size() == 0) checkOutput("r_unexpected", 1, 0);
                else begin
                    checkOutput("rdata", rdata, exp_rdata.pop_front());
                    checkOutput("rresp", rresp, exp_rresp.pop_front());
                end
                r_seen++;
                r_hold = 0;
            end else begin
                r_hold = rvalid;
                r_hold_data = rdata;
                r_hold_resp = rresp;
            end
        end
    end

    // Random back-pressure on B and R when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                bready = ($urandom_range(0, 3) != 0);
                rready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        exp_b.delete(); exp_rdata.delete(); exp_rresp.delete();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 0);
        checkOutput("reset_rdata", rdata, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("readies_after_reset", {awready, wready, arready}, 3'b111);
    endtask

    // Drive AW and W with independent start delays; push the expected B on completion.
    task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done = 0, w_done = 0, fire_aw, fire_w;
        int t = 0;
        int idx;
        awaddr = addr; wdata = data; wstrb = strb; awprot = 3'($urandom);
        while (!(aw_done && w_done) && t < 60) begin
            awvalid = !aw_done && (t >= aw_dly);
            wvalid  = !w_done && (t >= w_dly);
            fire_aw = awvalid && awready;
            fire_w  = wvalid && wready;
            @(posedge clk);
            #1;
            awvalid = 0;
            wvalid  = 0;
            if (fire_w && !fire_aw && !aw_done) begin
                checkOutput("wready_drop", wready, 0);
                checkOutput("awready_idle", awready, 1);
            end
            if (fire_aw && !fire_w && !w_done) begin
                checkOutput("awready_drop", awready, 0);
                checkOutput("wready_idle", wready, 1);
            end
            aw_done |= fire_aw;
            w_done  |= fire_w;
            t++;
        end
        if (!(aw_done && w_done)) begin
            checkOutput("write_hs_timeout", {aw_done, w_done}, 2'b11);
        end else if (model_in_range(addr)) begin
            idx = int'((addr - BASE) >> 2);
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(2'b11);
        end
    endtask

    task automatic issue_read(input logic [31:0] addr);
        bit done = 0, fire;
        int t = 0;
        araddr = addr; arprot = 3'($urandom);
        while (!done && t < 60) begin
            arvalid = 1;
            fire = arready;
            @(posedge clk);
            #1;
            done = fire;
            t++;
        end
        arvalid = 0;
        if (!done) checkOutput("ar_hs_timeout", 0, 1);
        else if (model_in_range(addr)) begin
            exp_rdata.push_back(model_mem[int'((addr - BASE) >> 2)]);
            exp_rresp.push_back(2'b00);
        end else begin
            exp_rdata.push_back(32'h0);
            exp_rresp.push_back(2'b11);
        end
    endtask

    task automatic wait_b(input int target);
        int t = 0;
        while (b_seen < target && t < 100) begin @(posedge clk); #1; t++; end
        if (b_seen < target) checkOutput("b_wait_timeout", b_seen, target);
    endtask

    task automatic wait_r(input int target);
        int t = 0;
        while (r_seen < target && t < 100) begin @(posedge clk); #1; t++; end
        if (r_seen < target) checkOutput("r_wait_timeout", r_seen, target);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int aw_dly, input int w_dly);
        int target;
        target = b_seen + 1;
        issue_write(addr, data, strb, aw_dly, w_dly);
        wait_b(target);
    endtask

    task automatic read_check(input logic [31:0] addr);
        int target;
        target = r_seen + 1;
        issue_read(addr);
        wait_r(target);
    endtask

    logic [31:0] raddr;
    int          k, b_base;
    bit          saw_rvalid;

    initial begin
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 0; arprot = 0;
        bready = 1; rready = 1;
        do_reset();

        applyStimulus(BASE + 4, 32'hDEADBEEF, 4'hF, 0, 0);
        read_check(BASE + 4);

        applyStimulus(BASE + 8, 32'h1234_5678, 4'hF, 3, 0);
        applyStimulus(BASE + 16, 32'h0BAD_F00D, 4'h5, 0, 2);
        read_check(BASE + 8);
        read_check(BASE + 16);

        applyStimulus(BASE + 12, 32'h1122_3344, 4'hF, 0, 0);
        applyStimulus(BASE + 12, 32'h0000_AB00, 4'b0010, 1, 0);
        read_check(BASE + 12);

        applyStimulus(BASE + DEPTH*4, 32'hFFFF_FFFF, 4'hF, 0, 0);
        applyStimulus(BASE - 4, 32'hFFFF_FFFF, 4'hF, 0, 0);
        read_check(BASE + DEPTH*4);
        read_check(BASE - 4);
        read_check(BASE + (DEPTH-1)*4 + 3);

        bready = 0;
        b_base = b_seen;
        issue_write(BASE - 8, 32'h5555_5555, 4'hF, 0, 0);
        k = 0;
        while (!bvalid && k < 20) begin @(posedge clk); #1; k++; end
        checkOutput("first_bvalid", bvalid, 1);
        issue_write(BASE + 20, 32'hCAFE_F00D, 4'hF, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("no_commit_while_bvalid", b_seen, b_base);
        checkOutput("held_bresp", bresp, 2'b11);
        bready = 1;
        wait_b(b_base + 2);
        read_check(BASE + 20);

        issue_read(BASE + 4);
        saw_rvalid = 0;
        for (k = 1; k <= 12 && !saw_rvalid; k++) begin
            @(posedge clk);
            #1;
            saw_rvalid = rvalid;
        end
        checkOutput("rd_latency_edges", k - 1, RD_LAT + 1);
        wait_r(r_seen + 1);

        issue_read(BASE + 8);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_awready", awready, 0);
        exp_rdata.delete(); exp_rresp.delete(); exp_b.delete();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        saw_rvalid = 0;
        repeat (8) begin @(posedge clk); #1; saw_rvalid |= rvalid; end
        checkOutput("rvalid_after_mid_reset", saw_rvalid, 0);
        read_check(BASE + 4);

        rand_ready = 1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                8:       raddr = BASE + DEPTH*4 + $urandom_range(0, 255);
                9:       raddr = BASE - 1 - $urandom_range(0, 255);
                default: raddr = BASE + $urandom_range(0, DEPTH*4 - 1);
            endcase
            if ($urandom_range(0, 1) == 1)
                applyStimulus(raddr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                read_check(raddr);
        end
        rand_ready = 0;
        bready = 1;
        rready = 1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("b_queue_drained", exp_b.size(), 0);
        checkOutput("r_queue_drained", exp_rdata.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
